// File: rtl/sc_regshifter_pkg.sv
// Shared constants for the multi-mode shift register.
// Holds the shift-mode encodings carried on SC_RegSHIFTER_mode_In and the
// FSM state encoding used by the top level.
package sc_regshifter_pkg;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ROL = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ASR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sc_regshifter_prescaler.sv
// Step-rate prescaler for the shift register.
// Counts 0..STEP_PERIOD-1 while enabled and wraps. stepTick is a purely
// combinational flag that is high while enabled and the count sits at its
// last value, so the step lands on the edge that wraps the counter.
// Ports:
//   clk      - system clock
//   clear    - synchronous clear to 0 (has priority over enable)
//   enable   - count enable
//   stepTick - step strobe for the current cycle
module sc_regshifter_prescaler #(
  parameter int STEP_PERIOD = 1,
  parameter int PRESCWIDTH  = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic stepTick
);

  localparam logic [PRESCWIDTH-1:0] LAST_COUNT = PRESCWIDTH'(STEP_PERIOD - 1);

  logic [PRESCWIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST_COUNT) count <= '0;
      else                     count <= count + 1'b1;
    end
  end

  assign stepTick = enable && (count == LAST_COUNT);

endmodule

// File: rtl/sc_regshifter_multimode.sv
// Multi-mode shift register with a start/busy/done handshake.
// Loads a DATAWIDTH-bit word in IDLE, then on start performs "amount"
// single-bit LSL/LSR/ROL/ROR/ASR steps, one every STEP_PERIOD clocks.
// Reserved modes still count steps but leave data and serial_Out alone.
// Ports:
//   SC_RegSHIFTER_CLOCK_50      - clock, all state on the rising edge
//   SC_RegSHIFTER_RESET_InHigh  - synchronous active-high reset
//   SC_RegSHIFTER_load_In       - parallel load (IDLE only, beats start)
//   SC_RegSHIFTER_data_InBUS    - parallel load word
//   SC_RegSHIFTER_start_In      - start a shift command (IDLE only)
//   SC_RegSHIFTER_mode_In       - shift mode, see sc_regshifter_pkg
//   SC_RegSHIFTER_amount_In     - number of single-bit steps
//   SC_RegSHIFTER_serial_In     - fill bit for LSL/LSR, sampled per step
//   SC_RegSHIFTER_data_OutBUS   - register contents
//   SC_RegSHIFTER_serial_Out    - last bit shifted or rotated out
//   SC_RegSHIFTER_busy_Out      - high while shifting
//   SC_RegSHIFTER_done_Out      - one-cycle completion pulse
module sc_regshifter_multimode
  import sc_regshifter_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int AMOUNTWIDTH = 3,
  parameter int STEP_PERIOD = 1,
  parameter int PRESCWIDTH  = 4
) (
  input  logic                   SC_RegSHIFTER_CLOCK_50,
  input  logic                   SC_RegSHIFTER_RESET_InHigh,
  input  logic                   SC_RegSHIFTER_load_In,
  input  logic [DATAWIDTH-1:0]   SC_RegSHIFTER_data_InBUS,
  input  logic                   SC_RegSHIFTER_start_In,
  input  logic [2:0]             SC_RegSHIFTER_mode_In,
  input  logic [AMOUNTWIDTH-1:0] SC_RegSHIFTER_amount_In,
  input  logic                   SC_RegSHIFTER_serial_In,
  output logic [DATAWIDTH-1:0]   SC_RegSHIFTER_data_OutBUS,
  output logic                   SC_RegSHIFTER_serial_Out,
  output logic                   SC_RegSHIFTER_busy_Out,
  output logic                   SC_RegSHIFTER_done_Out
);

  state_t                 state;
  state_t                 nextState;
  logic [2:0]             modeLatched;
  logic [AMOUNTWIDTH-1:0] remaining;
  logic [DATAWIDTH-1:0]   dataReg;
  logic                   serialReg;
  logic [DATAWIDTH-1:0]   nextData;
  logic                   nextSerial;
  logic                   stepTick;
  logic                   prescClear;

  // The prescaler is held at 0 outside SHIFT, so every command starts
  // with a fresh count.
  assign prescClear = SC_RegSHIFTER_RESET_InHigh || (state != ST_SHIFT);

  sc_regshifter_prescaler #(
    .STEP_PERIOD (STEP_PERIOD),
    .PRESCWIDTH  (PRESCWIDTH)
  ) uPrescaler (
    .clk      (SC_RegSHIFTER_CLOCK_50),
    .clear    (prescClear),
    .enable   (state == ST_SHIFT),
    .stepTick (stepTick)
  );

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
    if (SC_RegSHIFTER_RESET_InHigh) state <= ST_IDLE;
    else                            state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (!SC_RegSHIFTER_load_In && SC_RegSHIFTER_start_In) begin
          if (SC_RegSHIFTER_amount_In == '0) nextState = ST_DONE;
          else                               nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stepTick && (remaining == AMOUNTWIDTH'(1))) nextState = ST_DONE;
      end
      ST_DONE:  nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Single-bit step result for the latched mode.
  always_comb begin
    nextData   = dataReg;
    nextSerial = serialReg;
    case (modeLatched)
      MODE_LSL: begin
        nextData   = {dataReg[DATAWIDTH-2:0], SC_RegSHIFTER_serial_In};
        nextSerial = dataReg[DATAWIDTH-1];
      end
      MODE_LSR: begin
        nextData   = {SC_RegSHIFTER_serial_In, dataReg[DATAWIDTH-1:1]};
        nextSerial = dataReg[0];
      end
      MODE_ROL: begin
        nextData   = {dataReg[DATAWIDTH-2:0], dataReg[DATAWIDTH-1]};
        nextSerial = dataReg[DATAWIDTH-1];
      end
      MODE_ROR: begin
        nextData   = {dataReg[0], dataReg[DATAWIDTH-1:1]};
        nextSerial = dataReg[0];
      end
      MODE_ASR: begin
        nextData   = {dataReg[DATAWIDTH-1], dataReg[DATAWIDTH-1:1]};
        nextSerial = dataReg[0];
      end
      default: begin
        nextData   = dataReg;
        nextSerial = serialReg;
      end
    endcase
  end

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      dataReg     <= '0;
      serialReg   <= 1'b0;
      modeLatched <= MODE_LSL;
      remaining   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SC_RegSHIFTER_load_In) begin
            dataReg   <= SC_RegSHIFTER_data_InBUS;
            serialReg <= 1'b0;
          end else if (SC_RegSHIFTER_start_In) begin
            modeLatched <= SC_RegSHIFTER_mode_In;
            remaining   <= SC_RegSHIFTER_amount_In;
          end
        end
        ST_SHIFT: begin
          if (stepTick) begin
            dataReg   <= nextData;
            serialReg <= nextSerial;
            remaining <= remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SC_RegSHIFTER_data_OutBUS = dataReg;
  assign SC_RegSHIFTER_serial_Out  = serialReg;
  assign SC_RegSHIFTER_busy_Out    = (state == ST_SHIFT);
  assign SC_RegSHIFTER_done_Out    = (state == ST_DONE);

endmodule

// File: tb/tb_sc_regshifter_multimode.sv
// Bench for sc_regshifter_multimode: one instance with STEP_PERIOD=1 and
// one with STEP_PERIOD=4, each tracked by an arithmetic model that is
// compared against the outputs on every falling edge.
module tb_sc_regshifter_multimode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic       load[2];
  logic       start[2];
  logic       serIn[2];
  logic [7:0] dIn[2];
  logic [2:0] mode[2];
  logic [2:0] amt[2];
  logic [7:0] dOut[2];
  logic       sOut[2];
  logic       busy[2];
  logic       done[2];

  int  per[2];
  int  mData[2];
  int  mSer[2];
  int  mBusy[2];
  int  mDone[2];
  int  nChecks = 0;
  int  nPass   = 0;
  bit  armed   = 1'b0;

  sc_regshifter_multimode #(
    .DATAWIDTH(8), .AMOUNTWIDTH(3), .STEP_PERIOD(1), .PRESCWIDTH(4)
  ) dut0 (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst[0]),
    .SC_RegSHIFTER_load_In      (load[0]),
    .SC_RegSHIFTER_data_InBUS   (dIn[0]),
    .SC_RegSHIFTER_start_In     (start[0]),
    .SC_RegSHIFTER_mode_In      (mode[0]),
    .SC_RegSHIFTER_amount_In    (amt[0]),
    .SC_RegSHIFTER_serial_In    (serIn[0]),
    .SC_RegSHIFTER_data_OutBUS  (dOut[0]),
    .SC_RegSHIFTER_serial_Out   (sOut[0]),
    .SC_RegSHIFTER_busy_Out     (busy[0]),
    .SC_RegSHIFTER_done_Out     (done[0])
  );

  sc_regshifter_multimode #(
    .DATAWIDTH(8), .AMOUNTWIDTH(3), .STEP_PERIOD(4), .PRESCWIDTH(4)
  ) dut1 (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst[1]),
    .SC_RegSHIFTER_load_In      (load[1]),
    .SC_RegSHIFTER_data_InBUS   (dIn[1]),
    .SC_RegSHIFTER_start_In     (start[1]),
    .SC_RegSHIFTER_mode_In      (mode[1]),
    .SC_RegSHIFTER_amount_In    (amt[1]),
    .SC_RegSHIFTER_serial_In    (serIn[1]),
    .SC_RegSHIFTER_data_OutBUS  (dOut[1]),
    .SC_RegSHIFTER_serial_Out   (sOut[1]),
    .SC_RegSHIFTER_busy_Out     (busy[1]),
    .SC_RegSHIFTER_done_Out     (done[1])
  );

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model of one step on an 8-bit value, written as plain arithmetic.
  task automatic modelStep(input int i, input int md, input int fill);
    int d;
    d = mData[i];
    case (md)
      0: begin mData[i] = (d * 2) % 256 + fill;         mSer[i] = d / 128; end
      1: begin mData[i] = d / 2 + fill * 128;           mSer[i] = d % 2;   end
      2: begin mData[i] = (d * 2) % 256 + d / 128;      mSer[i] = d / 128; end
      3: begin mData[i] = d / 2 + (d % 2) * 128;        mSer[i] = d % 2;   end
      4: begin mData[i] = d / 2 + ((d >= 128) ? 128 : 0); mSer[i] = d % 2; end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d data", i),   dOut[i], mData[i]);
        check($sformatf("dut%0d serial", i), sOut[i], mSer[i]);
        check($sformatf("dut%0d busy", i),   busy[i], mBusy[i]);
        check($sformatf("dut%0d done", i),   done[i], mDone[i]);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic doLoad(input int i, input int v);
    load[i] = 1'b1;
    dIn[i]  = 8'(v);
    cycle();
    load[i]  = 1'b0;
    mData[i] = v;
    mSer[i]  = 0;
  endtask

  // Issue a shift command. disturbAt pulses load(0xFF)+start during SHIFT,
  // abortAt asserts reset ahead of that step edge; 0 disables either.
  task automatic doShift(input int i, input int md, input int n, input int fill,
                         input int disturbAt, input int abortAt);
    start[i] = 1'b1;
    mode[i]  = 3'(md);
    amt[i]   = 3'(n);
    serIn[i] = fill[0];
    cycle();
    start[i] = 1'b0;
    if (n == 0) begin
      mDone[i] = 1;
      cycle();
      mDone[i] = 0;
      return;
    end
    mBusy[i] = 1;
    for (int c = 1; c <= n * per[i]; c++) begin
      if (c == disturbAt) begin
        load[i]  = 1'b1;
        dIn[i]   = 8'hFF;
        start[i] = 1'b1;
      end
      if (c == abortAt) rst[i] = 1'b1;
      cycle();
      load[i]  = 1'b0;
      start[i] = 1'b0;
      if (c == abortAt) begin
        rst[i]   = 1'b0;
        mData[i] = 0;
        mSer[i]  = 0;
        mBusy[i] = 0;
        mDone[i] = 0;
        return;
      end
      if (c % per[i] == 0) modelStep(i, md, fill);
      if (c == n * per[i]) begin
        mBusy[i] = 0;
        mDone[i] = 1;
      end
    end
    cycle();
    mDone[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    per[0] = 1;
    per[1] = 4;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; load[i] = 1'b0; start[i] = 1'b0; serIn[i] = 1'b0;
      dIn[i] = 8'h00; mode[i] = 3'd0; amt[i] = 3'd0;
      mData[i] = 0; mSer[i] = 0; mBusy[i] = 0; mDone[i] = 0;
    end
    idle(2);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    armed  = 1'b1;
    check("reset data", dOut[0], 0);
    check("reset busy", busy[1], 0);

    // ROL 0xB5 by 3
    doLoad(0, 'hB5);
    doShift(0, 2, 3, 0, 0, 0);
    check("rol data", dOut[0], 'hAD);
    check("rol serial", sOut[0], 1);
    idle(1);

    // ASR 0x90 by 2
    doLoad(0, 'h90);
    doShift(0, 4, 2, 0, 0, 0);
    check("asr data", dOut[0], 'hE4);
    check("asr serial", sOut[0], 0);

    // Zero amount: done next cycle, data unchanged
    doShift(0, 0, 0, 1, 0, 0);
    check("zero data", dOut[0], 'hE4);

    // Load beats start
    load[0] = 1'b1; start[0] = 1'b1; dIn[0] = 8'h3C; mode[0] = 3'd0; amt[0] = 3'd2;
    cycle();
    load[0] = 1'b0; start[0] = 1'b0;
    mData[0] = 'h3C; mSer[0] = 0;
    idle(3);
    check("loadprio data", dOut[0], 'h3C);
    check("loadprio busy", busy[0], 0);

    // LSR fill 1 with load/start pulsed mid-shift
    doLoad(0, 'h5A);
    doShift(0, 1, 3, 1, 1, 0);
    check("disturb data", dOut[0], 'hEB);
    check("disturb serial", sOut[0], 0);

    // Reserved mode 6: timing kept, data untouched
    doShift(0, 6, 3, 1, 0, 0);
    check("reserved data", dOut[0], 'hEB);

    // Abort a ROR by 5 at the 2nd step
    doLoad(0, 'h81);
    doShift(0, 3, 5, 0, 0, 2);
    check("abort data", dOut[0], 0);
    check("abort busy", busy[0], 0);
    idle(8);

    // Paced LSL on the STEP_PERIOD=4 instance
    doLoad(1, 'h01);
    doShift(1, 0, 4, 1, 0, 0);
    check("paced data", dOut[1], 'h1F);
    check("paced serial", sOut[1], 0);
    idle(2);

    armed = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
